// File: rtl/iic_slave.sv
// Bit-level IIC target: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// byte write strobe and byte read request towards local logic. No stretching, no arbitration.
module iic_slave #(
  parameter logic [6:0] ADDR = 7'h50
) (
  input  logic       I_clk,
  input  logic       I_rstn,
  input  logic       I_scl,
  input  logic       I_sda,
  output logic       O_sda,
  output logic [7:0] O_wr_data,
  output logic       O_wr_valid,
  output logic       O_rd_req,
  input  logic [7:0] I_rd_data,
  output logic       O_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_IGNORE
  } state_t;

  state_t     state_q, state_n;
  logic [2:0] bit_cnt_q, bit_cnt_n;
  logic [6:0] shift_q, shift_n;
  logic [7:0] tx_q, tx_n;
  logic       rw_q, rw_n;
  logic       byte_done_q, byte_done_n;
  logic       sda_n;
  logic [7:0] wr_data_n;
  logic       wr_valid_n, rd_req_n;

  logic scl_s1, scl_s2, scl_h;
  logic sda_s1, sda_s2, sda_h;
  logic scl_rise, scl_fall, start_det, stop_det;

  // Both lines share identical synchronizer depth so their relative ordering survives.
  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_h <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_h <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every register sample the pre-edge values,
      // which is what turns these three flops into a shift chain.
      scl_s1 <= I_scl; scl_s2 <= scl_s1; scl_h <= scl_s2;
      sda_s1 <= I_sda; sda_s2 <= sda_s1; sda_h <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_h;
  assign scl_fall  = ~scl_s2 & scl_h;
  assign start_det = scl_s2 & sda_h & ~sda_s2;
  assign stop_det  = scl_s2 & ~sda_h & sda_s2;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    state_n     = state_q;
    bit_cnt_n   = bit_cnt_q;
    shift_n     = shift_q;
    tx_n        = O_rd_req ? I_rd_data : tx_q;
    rw_n        = rw_q;
    byte_done_n = byte_done_q;
    sda_n       = O_sda;
    wr_data_n   = O_wr_data;
    wr_valid_n  = 1'b0;
    rd_req_n    = 1'b0;

    if (start_det) begin
      state_n     = S_ADDR;
      bit_cnt_n   = 3'd0;
      byte_done_n = 1'b0;
      sda_n       = 1'b1;
    end else if (stop_det) begin
      state_n     = S_IDLE;
      byte_done_n = 1'b0;
      sda_n       = 1'b1;
    end else begin
      unique case (state_q)
        S_ADDR: begin
          if (scl_rise) begin
            shift_n   = {shift_q[5:0], sda_s2};
            bit_cnt_n = 3'(bit_cnt_q + 3'd1);
            if (bit_cnt_q == 3'd7) begin
              if (shift_q == ADDR) begin
                rw_n        = sda_s2;
                rd_req_n    = sda_s2;
                byte_done_n = 1'b1;
              end else begin
                state_n = S_IGNORE;
              end
            end
          end else if (scl_fall && byte_done_q) begin
            sda_n       = 1'b0;
            byte_done_n = 1'b0;
            state_n     = S_ADDR_ACK;
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              sda_n     = tx_q[7];
              tx_n      = {tx_q[6:0], 1'b0};
              bit_cnt_n = 3'd1;
              state_n   = S_READ;
            end else begin
              sda_n     = 1'b1;
              bit_cnt_n = 3'd0;
              state_n   = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (scl_rise) begin
            shift_n   = {shift_q[5:0], sda_s2};
            bit_cnt_n = 3'(bit_cnt_q + 3'd1);
            if (bit_cnt_q == 3'd7) begin
              wr_data_n   = {shift_q, sda_s2};
              wr_valid_n  = 1'b1;
              byte_done_n = 1'b1;
            end
          end else if (scl_fall && byte_done_q) begin
            sda_n       = 1'b0;
            byte_done_n = 1'b0;
            state_n     = S_WRITE_ACK;
          end
        end
        S_WRITE_ACK: begin
          if (scl_fall) begin
            sda_n   = 1'b1;
            state_n = S_WRITE;
          end
        end
        S_READ: begin
          // bit_cnt counts bits already driven; wrapping to 0 means all eight are out.
          if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              sda_n   = 1'b1;
              state_n = S_READ_ACK;
            end else begin
              sda_n     = tx_q[7];
              tx_n      = {tx_q[6:0], 1'b0};
              bit_cnt_n = 3'(bit_cnt_q + 3'd1);
            end
          end
        end
        S_READ_ACK: begin
          if (scl_rise) begin
            if (sda_s2) begin
              state_n = S_IGNORE;
            end else begin
              rd_req_n = 1'b1;
            end
          end else if (scl_fall) begin
            sda_n     = tx_q[7];
            tx_n      = {tx_q[6:0], 1'b0};
            bit_cnt_n = 3'd1;
            state_n   = S_READ;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      tx_q        <= 8'd0;
      rw_q        <= 1'b0;
      byte_done_q <= 1'b0;
      O_sda       <= 1'b1;
      O_wr_data   <= 8'h00;
      O_wr_valid  <= 1'b0;
      O_rd_req    <= 1'b0;
    end else begin
      state_q     <= state_n;
      bit_cnt_q   <= bit_cnt_n;
      shift_q     <= shift_n;
      tx_q        <= tx_n;
      rw_q        <= rw_n;
      byte_done_q <= byte_done_n;
      O_sda       <= sda_n;
      O_wr_data   <= wr_data_n;
      O_wr_valid  <= wr_valid_n;
      O_rd_req    <= rd_req_n;
    end
  end

  assign O_busy = (state_q != S_IDLE) && (state_q != S_IGNORE);

endmodule

// File: tb/tb_iic_slave.sv
// Directed bench for iic_slave: a bit-banged IIC master on a wired-AND SDA line
// with monitors that collect write strobes and count read requests.
module tb_iic_slave;

  logic       I_clk = 1'b0;
  logic       I_rstn = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       O_sda;
  logic [7:0] O_wr_data;
  logic       O_wr_valid;
  logic       O_rd_req;
  logic [7:0] I_rd_data;
  logic       O_busy;
  logic       sda_bus;

  int total = 0;
  int bad = 0;

  logic [7:0] rd_table [0:3];
  int         rd_cnt = 0;
  int         low_cnt = 0;
  int         wide_err = 0;
  logic       wr_prev = 1'b0;
  logic       rd_prev = 1'b0;
  logic [7:0] wr_q [$];

  always #5 I_clk = ~I_clk;

  assign sda_bus   = m_sda & O_sda;
  assign I_rd_data = rd_table[(rd_cnt > 0) ? rd_cnt - 1 : 0];

  iic_slave dut (
    .I_clk      (I_clk),
    .I_rstn     (I_rstn),
    .I_scl      (m_scl),
    .I_sda      (sda_bus),
    .O_sda      (O_sda),
    .O_wr_data  (O_wr_data),
    .O_wr_valid (O_wr_valid),
    .O_rd_req   (O_rd_req),
    .I_rd_data  (I_rd_data),
    .O_busy     (O_busy)
  );

  // The request counter advances before the next rising edge, so the table entry for
  // request N is what the DUT sees while O_rd_req is high.
  always @(negedge I_clk) begin
    if (O_wr_valid) wr_q.push_back(O_wr_data);
    if (O_wr_valid && wr_prev) wide_err++;
    if (O_rd_req && rd_prev) wide_err++;
    if (O_rd_req) rd_cnt++;
    if (!O_sda) low_cnt++;
    wr_prev = O_wr_valid;
    rd_prev = O_rd_req;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge I_clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_clk(3);
    m_scl = 1'b1; wait_clk(6);
    m_sda = 1'b0; wait_clk(6);
    m_scl = 1'b0; wait_clk(3);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_clk(3);
    m_scl = 1'b1; wait_clk(6);
    m_sda = 1'b1; wait_clk(6);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    wait_clk(3);
    m_scl = 1'b1; wait_clk(6);
    m_scl = 1'b0; wait_clk(3);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_clk(3);
    m_scl = 1'b1; wait_clk(3);
    b = sda_bus;  wait_clk(3);
    m_scl = 1'b0; wait_clk(3);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack);
  endtask

  task automatic test_reset();
    I_rstn = 1'b0; wait_clk(3);
    I_rstn = 1'b1; wait_clk(3);
    total++; if (O_sda !== 1'b1) begin bad++; $display("FAIL reset_sda got=%b exp=1", O_sda); end
    total++; if (O_wr_data !== 8'h00) begin bad++; $display("FAIL reset_wr_data got=%h exp=00", O_wr_data); end
    total++; if (O_wr_valid !== 1'b0) begin bad++; $display("FAIL reset_wr_valid got=%b exp=0", O_wr_valid); end
    total++; if (O_rd_req !== 1'b0) begin bad++; $display("FAIL reset_rd_req got=%b exp=0", O_rd_req); end
    total++; if (O_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", O_busy); end
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    int   w0 = wr_q.size();
    bus_start();
    total++; if (O_busy !== 1'b1) begin bad++; $display("FAIL wr_busy_start got=%b exp=1", O_busy); end
    write_byte(8'hA0, a0);
    write_byte(8'h3C, a1);
    write_byte(8'hC3, a2);
    total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL wr_acks got=%b exp=000", {a0, a1, a2}); end
    total++; if (O_busy !== 1'b1) begin bad++; $display("FAIL wr_busy_mid got=%b exp=1", O_busy); end
    bus_stop();
    total++; if (O_busy !== 1'b0) begin bad++; $display("FAIL wr_busy_stop got=%b exp=0", O_busy); end
    total++;
    if (wr_q.size() - w0 !== 2) begin
      bad++; $display("FAIL wr_count got=%0d exp=2", wr_q.size() - w0);
    end else if (wr_q[w0] !== 8'h3C || wr_q[w0+1] !== 8'hC3) begin
      bad++; $display("FAIL wr_bytes got=%h,%h exp=3c,c3", wr_q[w0], wr_q[w0+1]);
    end
    total++; if (O_wr_data !== 8'hC3) begin bad++; $display("FAIL wr_hold got=%h exp=c3", O_wr_data); end
  endtask

  task automatic test_read();
    logic       a;
    logic [7:0] d0, d1;
    int         r0 = rd_cnt;
    bus_start();
    write_byte(8'hA1, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL rd_addr_ack got=%b exp=0", a); end
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    total++; if (d0 !== 8'h96) begin bad++; $display("FAIL rd_byte0 got=%h exp=96", d0); end
    total++; if (d1 !== 8'h5A) begin bad++; $display("FAIL rd_byte1 got=%h exp=5a", d1); end
    wait_clk(4);
    total++; if (O_sda !== 1'b1) begin bad++; $display("FAIL rd_nack_release got=%b exp=1", O_sda); end
    bus_stop();
    total++; if (rd_cnt - r0 !== 2) begin bad++; $display("FAIL rd_req_count got=%0d exp=2", rd_cnt - r0); end
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    int   l0 = low_cnt;
    int   w0 = wr_q.size();
    int   r0 = rd_cnt;
    bus_start();
    write_byte(8'hA2, a0);
    total++; if (O_busy !== 1'b0) begin bad++; $display("FAIL mm_busy got=%b exp=0", O_busy); end
    write_byte(8'h00, a1);
    bus_stop();
    total++; if ({a0, a1} !== 2'b11) begin bad++; $display("FAIL mm_nacks got=%b exp=11", {a0, a1}); end
    total++; if (low_cnt - l0 !== 0) begin bad++; $display("FAIL mm_sda_low got=%0d exp=0", low_cnt - l0); end
    total++;
    if ((wr_q.size() - w0) + (rd_cnt - r0) !== 0) begin
      bad++; $display("FAIL mm_strobes got=%0d exp=0", (wr_q.size() - w0) + (rd_cnt - r0));
    end
  endtask

  task automatic test_repeated_start();
    logic       a0, a1, a2;
    logic [7:0] d;
    int         w0 = wr_q.size();
    int         r0 = rd_cnt;
    bus_start();
    write_byte(8'hA0, a0);
    write_byte(8'h11, a1);
    bus_start();
    write_byte(8'hA1, a2);
    read_byte(1'b1, d);
    bus_stop();
    total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL sr_acks got=%b exp=000", {a0, a1, a2}); end
    total++;
    if (wr_q.size() - w0 !== 1) begin
      bad++; $display("FAIL sr_wr_count got=%0d exp=1", wr_q.size() - w0);
    end else if (wr_q[w0] !== 8'h11) begin
      bad++; $display("FAIL sr_wr_byte got=%h exp=11", wr_q[w0]);
    end
    total++; if (d !== 8'h7E) begin bad++; $display("FAIL sr_rd_byte got=%h exp=7e", d); end
    total++; if (rd_cnt - r0 !== 1) begin bad++; $display("FAIL sr_rd_count got=%0d exp=1", rd_cnt - r0); end
  endtask

  task automatic test_abort();
    logic a0, a1, a2;
    int   w0 = wr_q.size();
    bus_start();
    write_byte(8'hA0, a0);
    for (int i = 0; i < 5; i++) write_bit(i[0]);
    bus_stop();
    total++; if (O_busy !== 1'b0) begin bad++; $display("FAIL ab_busy got=%b exp=0", O_busy); end
    total++; if (wr_q.size() - w0 !== 0) begin bad++; $display("FAIL ab_no_strobe got=%0d exp=0", wr_q.size() - w0); end
    bus_start();
    write_byte(8'hA0, a1);
    write_byte(8'h55, a2);
    bus_stop();
    total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL ab_acks got=%b exp=000", {a0, a1, a2}); end
    total++;
    if (wr_q.size() - w0 !== 1) begin
      bad++; $display("FAIL ab_next_count got=%0d exp=1", wr_q.size() - w0);
    end else if (wr_q[w0] !== 8'h55) begin
      bad++; $display("FAIL ab_next_byte got=%h exp=55", wr_q[w0]);
    end
  endtask

  task automatic test_async_reset();
    logic a;
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(i == 7 || i == 5);
    m_sda = 1'b1;
    wait_clk(2);
    total++; if (O_sda !== 1'b0) begin bad++; $display("FAIL ar_ack_driven got=%b exp=0", O_sda); end
    I_rstn = 1'b0;
    #1;
    total++; if (O_sda !== 1'b1) begin bad++; $display("FAIL ar_sda got=%b exp=1", O_sda); end
    total++;
    if ({O_busy, O_wr_valid, O_rd_req} !== 3'b000 || O_wr_data !== 8'h00) begin
      bad++; $display("FAIL ar_outputs got=%b%b%b/%h exp=000/00", O_busy, O_wr_valid, O_rd_req, O_wr_data);
    end
    wait_clk(3);
    m_scl = 1'b1;
    I_rstn = 1'b1;
    wait_clk(6);
    total++; if (O_busy !== 1'b0) begin bad++; $display("FAIL ar_idle got=%b exp=0", O_busy); end
    bus_start();
    write_byte(8'hA0, a);
    bus_stop();
    total++; if (a !== 1'b0) begin bad++; $display("FAIL ar_recover_ack got=%b exp=0", a); end
  endtask

  initial begin
    rd_table[0] = 8'h96;
    rd_table[1] = 8'h5A;
    rd_table[2] = 8'h7E;
    rd_table[3] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_repeated_start();
    test_abort();
    test_async_reset();
    total++; if (wide_err !== 0) begin bad++; $display("FAIL strobe_width got=%0d exp=0", wide_err); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iic_slave.md
# iic_slave

Bit-level IIC target that answers transactions generated by the team's IIC master driver. It oversamples SCL/SDA on the system clock and detects START/STOP. It matches a 7-bit address, ACKs, and exchanges bytes with local logic through a one-cycle strobe byte interface. It sits between the board-level open-drain pads and a register file or FIFO; no clock stretching and no arbitration.

## Interface
- ADDR, 7'h50, 7-bit target address compared against the first byte after START.
- I_clk  in  1  system clock; all logic on rising edge.
- I_rstn  in  1  reset, asynchronous, active-low.
- I_scl  in  1  SCL pad input (asynchronous).
- I_sda  in  1  SDA pad input (asynchronous).
- O_sda  out  1  SDA drive: 0 = pull low, 1 = release; reset 1.
- O_wr_data  out  8  last byte received in a write; reset 8'h00; holds until next byte.
- O_wr_valid  out  1  one-cycle pulse, O_wr_data valid; reset 0.
- O_rd_req  out  1  one-cycle pulse requesting the next read byte; reset 0.
- I_rd_data  in  8  read byte; must be valid in the cycle O_rd_req is high; sampled only then.
- O_busy  out  1  high while addressed (state not IDLE/IGNORE); reset 0.

## Operation
- Input path: 2-FF synchronizer per line (reset to 1), plus one history register per line (reset 1). rise/fall = history vs. synchronized value. SCL and SDA share identical paths, so their relative order is preserved.
- START: SDA fall while synced SCL high. STOP: SDA rise while synced SCL high. Both have priority over every state and all edge actions.
- START (incl. repeated): state ADDR, bit counter 0, O_sda 1. STOP: state IDLE, O_sda 1.
- States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
- Data on SDA is sampled at SCL rise. Slave changes O_sda only at SCL fall.
- Shift-in: MSB first, 3-bit counter increments at each SCL rise in ADDR/WRITE and wraps 7→0.
- ADDR, 8th rise: compare byte[7:1] with ADDR.
  - Mismatch: IGNORE; O_sda stays 1 until next START/STOP.
  - Match: remember R/W = byte[0]. If R/W=1, pulse O_rd_req and load I_rd_data into the transmit shift register in that same cycle.
  - Next SCL fall: O_sda 0, enter ADDR_ACK.
- ADDR_ACK, next SCL fall (end of 9th clock):
  - Write: release O_sda, enter WRITE.
  - Read: drive transmit bit 7, enter READ.
- WRITE, 8th rise: update O_wr_data and pulse O_wr_valid. Next fall: O_sda 0, enter WRITE_ACK. Every byte is ACKed. Following fall: release, back to WRITE.
- READ: at each fall, drive the next bit. After the 8th bit's fall, release O_sda and enter READ_ACK. Sample the master's ACK at the 9th rise:
  - 0: pulse O_rd_req, reload; at next fall drive bit 7, enter READ.
  - 1 (NACK): enter IGNORE, O_sda stays released.
- STOP or START mid-byte: partial byte discarded; no O_wr_valid.
- Reset mid-transfer: all outputs to reset values immediately; state IDLE. Bus traffic is ignored until a fresh START.

## Timing
- Latency: pad edge to detection is 2 cycles. O_sda, O_wr_valid and O_rd_req are registered and change 3 I_clk cycles after the pad edge.
- Requirements on the master:
  - Each SCL high and low phase ≥ 4 I_clk cycles, so slave SDA settles before the next rise.
  - SDA setup and hold around SCL edges ≥ 1 I_clk cycle.
- O_wr_valid and O_rd_req are exactly 1 cycle wide, at most one per byte.
- O_sda never changes while synced SCL is high, except the release forced by START/STOP detection.

## Test plan
- Write: START, 0xA0 (0x50 W), 0x3C, 0xC3, STOP.
  - Slave ACKs all 3 bytes.
  - O_wr_valid pulses twice: O_wr_data=0x3C, then 0xC3.
  - O_busy is 1 from START to STOP.
- Read: START, 0xA1, I_rd_data=0x96 then 0x5A; master ACKs the first byte and NACKs the second, then STOP.
  - SDA carries 10010110, 01011010.
  - O_rd_req pulses twice.
  - O_sda is 1 after the NACK.
- Mismatch: START, 0xA2.
  - O_sda stays 1 throughout.
  - No strobes; O_busy stays 0.
- Repeated start: START, 0xA0, 0x11, Sr, 0xA1, read 0x7E with NACK, STOP.
  - One O_wr_valid (0x11), then 0x7E on SDA.
- Abort: STOP after 5 bits of a write byte.
  - No O_wr_valid; state IDLE; the next START/0xA0 is ACKed normally.
- Reset: assert I_rstn=0 while the slave drives ACK low.
  - O_sda returns to 1 asynchronously; all outputs at reset values.
